// File: rtl/riscv_lsu.sv
// Multicycle load/store unit: owns the single a/d/we/rd/spo/ready bus port,
// performs byte-lane swap, load extension and read-modify-write for SB/SH.
// One request in flight; req_ready only in IDLE, bus waits held until ready or timeout.
//
// Ports: clk/rst (sync, active-high); req_* request in, resp_* one-cycle response out;
//        a/d/we/rd out and spo/ready in form the word-wide bus (no byte enables).
// Build option: define LSU_MISALIGN_SPLIT_EN to split misaligned half/word accesses
//        into two aligned word accesses; otherwise misaligned requests end with err=1.
module riscv_lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter bit SWAP_BYTES = 1'b1,
   parameter int TIMEOUT    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic [1:0]            resp_err,
   output logic [ADDR_WIDTH-1:0] a,
   output logic [31:0]           d,
   output logic                  we,
   output logic                  rd,
   input  logic [31:0]           spo,
   input  logic                  ready
);

   typedef enum logic [3:0] {
      S_IDLE, S_RD, S_WR, S_RMW_RD, S_RMW_WR,
`ifdef LSU_MISALIGN_SPLIT_EN
      S_RD2, S_RMW_RD2, S_RMW_WR2,
`endif
      S_RESP
   } state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   function automatic logic [31:0] swap32(input logic [31:0] w);
      swap32 = SWAP_BYTES ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
   endfunction

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [1:0]              size_q, size_d;
   logic                    uns_q, uns_d;
   logic [31:0]             rword_q, rword_d;
   logic [31:0]             rdata_q, rdata_d;
   logic [1:0]              err_q, err_d;
   logic [CW-1:0]           cnt_q, cnt_d;
`ifdef LSU_MISALIGN_SPLIT_EN
   logic                    mis_q, mis_d;
`endif

   logic        second;     // accessing the upper word of a split pair
   logic [31:0] spo_cpu, ld_word, ld_ext, wr_word;
   logic [63:0] pair, mask64, dat64, merged;
   logic [31:0] size_mask;
   logic        req_illegal, req_mis, to_hit;

   // Datapath helpers; all lane math is done on a {word1, word0} pair shifted by the
   // byte offset, so aligned and split accesses share one path.
   always_comb begin
      second = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      second = (state_q == S_RD2) || (state_q == S_RMW_RD2) || (state_q == S_RMW_WR2);
`endif
      spo_cpu = swap32(spo);
      pair    = {second ? spo_cpu : 32'h0, second ? rword_q : spo_cpu};
      ld_word = 32'(pair >> {addr_q[1:0], 3'b000});
      case (size_q)
         2'd0:    ld_ext = {{24{~uns_q & ld_word[7]}}, ld_word[7:0]};
         2'd1:    ld_ext = {{16{~uns_q & ld_word[15]}}, ld_word[15:0]};
         default: ld_ext = ld_word;
      endcase
      case (size_q)
         2'd0:    size_mask = 32'h0000_00FF;
         2'd1:    size_mask = 32'h0000_FFFF;
         default: size_mask = 32'hFFFF_FFFF;
      endcase
      mask64  = {32'h0, size_mask} << {addr_q[1:0], 3'b000};
      dat64   = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
      merged  = ({rword_q, rword_q} & ~mask64) | (dat64 & mask64);
      wr_word = second ? merged[63:32] : merged[31:0];
      req_illegal = (req_size == 2'd3);
      req_mis     = ((req_size == 2'd1) && req_addr[0]) ||
                    ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
      to_hit      = (TIMEOUT > 0) && (cnt_q == TO_LAST);
   end

   assign req_ready  = (state_q == S_IDLE) && !rst;
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = resp_valid ? rdata_q : 32'h0;
   assign resp_err   = resp_valid ? err_q : 2'd0;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
      rword_d = rword_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
      mis_d   = mis_q;
`endif
      a  = '0;
      d  = 32'h0;
      we = 1'b0;
      rd = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               size_d  = req_size;
               uns_d   = req_unsigned;
               rdata_d = 32'h0;
               err_d   = 2'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
               mis_d   = req_mis;
               if (req_illegal) begin
                  err_d   = 2'd1;
                  state_d = S_RESP;
               end else if (req_we)
                  state_d = (req_size == 2'd2 && !req_mis) ? S_WR : S_RMW_RD;
               else
                  state_d = S_RD;
`else
               if (req_illegal || req_mis) begin
                  err_d   = 2'd1;
                  state_d = S_RESP;
               end else if (req_we)
                  state_d = (req_size == 2'd2) ? S_WR : S_RMW_RD;
               else
                  state_d = S_RD;
`endif
            end
         end
         S_RD: begin
            rd = 1'b1;
            if (ready) begin
               rword_d = spo_cpu;
               rdata_d = ld_ext;
               state_d = S_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
               if (mis_q) state_d = S_RD2;
`endif
            end
         end
         S_WR: begin
            we = 1'b1;
            d  = swap32(wdata_q);
            if (ready) state_d = S_RESP;
         end
         S_RMW_RD: begin
            rd = 1'b1;
            if (ready) begin
               rword_d = spo_cpu;
               state_d = S_RMW_WR;
            end
         end
         S_RMW_WR: begin
            we = 1'b1;
            d  = swap32(wr_word);
            if (ready) begin
               state_d = S_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
               if (mis_q) state_d = S_RMW_RD2;
`endif
            end
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         S_RD2: begin
            rd = 1'b1;
            if (ready) begin
               rdata_d = ld_ext;
               state_d = S_RESP;
            end
         end
         S_RMW_RD2: begin
            rd = 1'b1;
            if (ready) begin
               rword_d = spo_cpu;
               state_d = S_RMW_WR2;
            end
         end
         S_RMW_WR2: begin
            we = 1'b1;
            d  = swap32(wr_word);
            if (ready) state_d = S_RESP;
         end
`endif
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (rd || we) begin
         a = {addr_q[ADDR_WIDTH-1:2] + {{(ADDR_WIDTH-3){1'b0}}, second}, 2'b00};
         // Abandon the access entirely; a pending RMW write is never issued.
         if (!ready && to_hit) begin
            state_d = S_RESP;
            err_d   = 2'd2;
            rdata_d = 32'h0;
         end
      end
      // Each new strobe phase restarts the wait counter.
      cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         rword_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 2'd0;
         cnt_q   <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         rword_q <= rword_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
`ifdef LSU_MISALIGN_SPLIT_EN
         mis_q   <= mis_d;
`endif
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu (SWAP_BYTES=1, TIMEOUT=3) with a small word memory on the bus.
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic [31:0] a;
   logic [31:0] d;
   logic        we;
   logic        rd;
   logic [31:0] spo;
   logic        ready;
   logic        bus_ready = 1'b1;

   riscv_lsu #(.ADDR_WIDTH(32), .SWAP_BYTES(1'b1), .TIMEOUT(3)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready)
   );

   always #5 clk = ~clk;

   // Bus memory, bus byte order; word index a[9:2].
   logic [31:0] mem [0:255];
   logic        poke_en = 1'b0;
   logic [7:0]  poke_idx = 8'h0;
   logic [31:0] poke_val = 32'h0;
   int          rd_cyc = 0, rd_done = 0, we_done = 0, resp_cnt = 0;
   logic [31:0] rd_addr_prev = 32'h0, rd_addr_last = 32'h0;

   assign ready = bus_ready;
   assign spo   = mem[a[9:2]];

   always @(posedge clk) begin
      if (poke_en) mem[poke_idx] <= poke_val;
      else if (we && ready) mem[a[9:2]] <= d;
      if (rd) rd_cyc <= rd_cyc + 1;
      if (rd && ready) begin
         rd_done      <= rd_done + 1;
         rd_addr_prev <= rd_addr_last;
         rd_addr_last <= a;
      end
      if (we && ready) we_done <= we_done + 1;
      if (resp_valid) resp_cnt <= resp_cnt + 1;
   end

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [7:0] idx, input logic [31:0] val);
      @(negedge clk);
      poke_en = 1'b1; poke_idx = idx; poke_val = val;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   int          r_lat;
   logic [31:0] r_rdata;
   logic [1:0]  r_err;

   // Issue one request and wait (bounded) for its response. Latency counts the
   // accept cycle as 1 and includes the resp_valid cycle.
   task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] ad, input logic [31:0] wd);
      int n;
      bit seen;
      @(negedge clk);
      req_valid = 1'b1; req_we = w; req_size = sz; req_unsigned = u;
      req_addr = ad; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      n = 2; seen = 1'b0; r_lat = 0; r_rdata = 32'hDEAD_DEAD; r_err = 2'd3;
      while (!seen && n < 40) begin
         if (resp_valid) begin
            seen = 1'b1; r_lat = n; r_rdata = resp_rdata; r_err = resp_err;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      check_eq({tag, "_resp_seen"}, 64'(seen), 64'd1);
   endtask

   int rd0, rdd0, we0, rs0;

   task automatic snap();
      rd0 = rd_cyc; rdd0 = rd_done; we0 = we_done; rs0 = resp_cnt;
   endtask

   initial begin
      // Reset with memory preload.
      poke(8'h40, 32'h7856_3412);   // 0x100: CPU 0x12345678
      poke(8'h44, 32'hFFFF_FF80);   // 0x110: CPU 0x80FFFFFF
      poke(8'h80, 32'h4433_2211);   // 0x200: CPU 0x11223344
      poke(8'h81, 32'h0000_0000);   // 0x204
      poke(8'h82, 32'hA5A5_A5A5);   // 0x208
      poke(8'hC0, 32'h1122_3344);   // 0x300: CPU 0x44332211
      poke(8'hC1, 32'h5566_7788);   // 0x304: CPU 0x88776655
      @(negedge clk);
      check_eq("rst_req_ready", 64'(req_ready), 64'd0);
      check_eq("rst_strobes", {62'd0, rd, we}, 64'd0);
      check_eq("rst_a_d", {a, d}, 64'd0);
      check_eq("rst_resp", {29'd0, resp_valid, resp_err, resp_rdata}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_req_ready", 64'(req_ready), 64'd1);

      // LW aligned with byte swap.
      snap();
      do_req("lw", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      check_eq("lw_rdata", r_rdata, 32'h1234_5678);
      check_eq("lw_err", r_err, 2'd0);
      check_eq("lw_lat", r_lat, 3);
      check_eq("lw_rd_cycles", rd_cyc - rd0, 1);

      do_req("lb", 1'b0, 2'd0, 1'b0, 32'h113, 32'h0);
      check_eq("lb_rdata", r_rdata, 32'hFFFF_FF80);
      do_req("lbu", 1'b0, 2'd0, 1'b1, 32'h113, 32'h0);
      check_eq("lbu_rdata", r_rdata, 32'h0000_0080);
      do_req("lh", 1'b0, 2'd1, 1'b0, 32'h112, 32'h0);
      check_eq("lh_rdata", r_rdata, 32'hFFFF_80FF);
      do_req("lhu", 1'b0, 2'd1, 1'b1, 32'h112, 32'h0);
      check_eq("lhu_rdata", r_rdata, 32'h0000_80FF);

      // SH upper half via read-modify-write.
      snap();
      do_req("sh", 1'b1, 2'd1, 1'b0, 32'h202, 32'hAAAA_BEEF);
      check_eq("sh_lat", r_lat, 4);
      check_eq("sh_err_rdata", {r_err, r_rdata}, 34'd0);
      check_eq("sh_mem", mem[8'h80], 32'h4433_EFBE);
      check_eq("sh_counts", {32'(rd_done - rdd0), 32'(we_done - we0)}, {32'd1, 32'd1});

      do_req("sb", 1'b1, 2'd0, 1'b0, 32'h201, 32'h0000_0055);
      check_eq("sb_lat", r_lat, 4);
      check_eq("sb_mem", mem[8'h80], 32'h4455_EFBE);

      do_req("sw", 1'b1, 2'd2, 1'b0, 32'h204, 32'hCAFE_F00D);
      check_eq("sw_lat", r_lat, 3);
      check_eq("sw_mem", mem[8'h81], 32'h0DF0_FECA);
      do_req("lw_back", 1'b0, 2'd2, 1'b0, 32'h204, 32'h0);
      check_eq("lw_back_rdata", r_rdata, 32'hCAFE_F00D);

      // Illegal size.
      snap();
      do_req("ill", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
      check_eq("ill_err", r_err, 2'd1);
      check_eq("ill_no_rd", rd_cyc - rd0, 0);

      // Misaligned word load.
      snap();
      do_req("mis", 1'b0, 2'd2, 1'b0, 32'h301, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
      check_eq("split_err", r_err, 2'd0);
      check_eq("split_rdata", r_rdata, 32'h5544_3322);
      check_eq("split_lat", r_lat, 4);
      check_eq("split_addrs", {rd_addr_prev, rd_addr_last}, {32'h300, 32'h304});
`else
      check_eq("mis_err", r_err, 2'd1);
      check_eq("mis_rdata", r_rdata, 32'h0);
      check_eq("mis_lat", r_lat, 2);
      check_eq("mis_no_rd", rd_cyc - rd0, 0);
      do_req("mis_sh", 1'b1, 2'd1, 1'b0, 32'h201, 32'h1234);
      check_eq("mis_sh_err", r_err, 2'd1);
      check_eq("mis_sh_mem", mem[8'h80], 32'h4455_EFBE);
`endif

      // Timeout: bus never answers, three wait cycles then err=2.
      bus_ready = 1'b0;
      snap();
      do_req("to", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      check_eq("to_err", r_err, 2'd2);
      check_eq("to_rdata", r_rdata, 32'h0);
      check_eq("to_lat", r_lat, 5);
      bus_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("to_rd_cycles", rd_cyc - rd0, 3);

      // Reset while the RMW read is waiting.
      bus_ready = 1'b0;
      snap();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h208; req_wdata = 32'h5A;
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("rmw_rd_active", 64'(rd), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_mid_rd", {62'd0, rd, we}, 64'd0);
      check_eq("rst_mid_req_ready", 64'(req_ready), 64'd0);
      rst = 1'b0;
      bus_ready = 1'b1;
      @(negedge clk);
      check_eq("rst_mid_req_ready_after", 64'(req_ready), 64'd1);
      repeat (4) @(negedge clk);
      check_eq("rst_mid_no_we", we_done - we0, 0);
      check_eq("rst_mid_no_resp", resp_cnt - rs0, 0);
      check_eq("rst_mid_mem", mem[8'h82], 32'hA5A5_A5A5);

      // Back-to-back operation after the abort.
      do_req("lw_after", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      check_eq("lw_after_rdata", r_rdata, 32'h1234_5678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
